// File: rtl/recip_pkg.sv
// Shared definitions for the reciprocal unit: pre-normalizer states and
// rounded Newton-Raphson seed constants.
package recip_pkg;

  typedef enum logic [1:0] {
    IDLE,
    NORM,
    MUL,
    DONE
  } prenorm_state_t;

  // round(n/17 * 2^(w-2)); 17 is odd so no ties occur
  function automatic logic [31:0] k_round(input int unsigned n,
                                          input int w);
    logic [63:0] t;
    t = ((64'(n) << (w - 2)) + 64'd8) / 64'd17;
    return t[31:0];
  endfunction

  function automatic logic [31:0] k1_const(input int w);
    return k_round(48, w);
  endfunction

  function automatic logic [31:0] k2_const(input int w);
    return k_round(32, w);
  endfunction

endpackage

// File: rtl/recip_prenorm_mac.sv
// Bit-serial shift-accumulate: acc <- (acc + bit*KM) >> 1 per step,
// with a step counter and a last-step flag.
module serial_mac
  import recip_pkg::*;
#(
  parameter int W = 16,
  parameter logic [W-1:0] KM = '0
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_clr,
  input  logic                 i_en,
  input  logic                 i_bit,
  output logic [$clog2(W)-1:0] o_idx,
  output logic [W:0]           o_acc_nxt,
  output logic                 o_done
);

  localparam int CW = $clog2(W);

  logic [W:0]    r_acc;
  logic [CW-1:0] r_cnt;
  logic [W:0]    w_sum;

  // acc never exceeds KM, so the W+1 bit sum cannot wrap
  assign w_sum     = r_acc + {1'b0, (i_bit ? KM : '0)};
  assign o_acc_nxt = w_sum >> 1;
  assign o_idx     = r_cnt;
  assign o_done    = i_en && (r_cnt == CW'(W - 1));

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (i_en) begin
      r_acc <= o_acc_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/recip_prenorm.sv
// Divisor pre-normalizer: left-justifies the divisor and forms the
// seed X0 = K1 - K2*x with a bit-serial multiplier.
module recip_prenorm
  import recip_pkg::*;
#(
  parameter int W = 16
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_valid,
  output logic                 o_ready,
  input  logic [W-1:0]         i_divisor,
  output logic                 o_valid,
  input  logic                 i_ready,
  output logic [W-1:0]         o_x,
  output logic [W-1:0]         o_x0,
  output logic [$clog2(W)-1:0] o_shift,
  output logic                 o_dz
);

  localparam int SW = $clog2(W);
  localparam logic [31:0] K1F = k1_const(W);
  localparam logic [31:0] K2F = k2_const(W);
  localparam logic [W-1:0] K1 = K1F[W-1:0];
  localparam logic [W-1:0] K2 = K2F[W-1:0];

  prenorm_state_t r_state, w_nxt;

  logic [W-1:0]  r_x;
  logic [W-1:0]  r_x0;
  logic [SW-1:0] r_shift;
  logic          r_dz;

  logic          w_cap;
  logic          w_capz;
  logic          w_shl;
  logic          w_clr;
  logic          w_en;
  logic          w_done;
  logic [SW-1:0] w_idx;
  logic [W:0]    w_acc_nxt;

  serial_mac #(
    .W  (W),
    .KM (K2)
  ) u_mac (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clr     (w_clr),
    .i_en      (w_en),
    .i_bit     (r_x[w_idx]),
    .o_idx     (w_idx),
    .o_acc_nxt (w_acc_nxt),
    .o_done    (w_done)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nxt;
  end

  always_comb begin
    w_nxt  = r_state;
    w_cap  = 1'b0;
    w_capz = 1'b0;
    w_shl  = 1'b0;
    w_clr  = 1'b0;
    w_en   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_valid) begin
          if (i_divisor != '0) begin
            w_cap = 1'b1;
            w_clr = 1'b1;
            w_nxt = NORM;
          end else begin
            w_capz = 1'b1;
            w_nxt  = DONE;
          end
        end
      end
      NORM: begin
        if (r_x[W-1]) begin
          w_clr = 1'b1;
          w_nxt = MUL;
        end else begin
          w_shl = 1'b1;
        end
      end
      MUL: begin
        w_en = 1'b1;
        if (w_done) w_nxt = DONE;
      end
      DONE: begin
        if (i_ready) w_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_x     <= '0;
      r_x0    <= '0;
      r_shift <= '0;
      r_dz    <= 1'b0;
    end else begin
      if (w_cap) begin
        r_x     <= i_divisor;
        r_shift <= '0;
        r_dz    <= 1'b0;
      end
      if (w_capz) begin
        r_x     <= '0;
        r_x0    <= '0;
        r_shift <= '0;
        r_dz    <= 1'b1;
      end
      if (w_shl) begin
        r_x     <= r_x << 1;
        r_shift <= r_shift + SW'(1);
      end
      if (w_done) r_x0 <= K1 - w_acc_nxt[W-1:0];
    end
  end

  assign o_ready = (r_state == IDLE);
  assign o_valid = (r_state == DONE);
  assign o_x     = r_x;
  assign o_x0    = r_x0;
  assign o_shift = r_shift;
  assign o_dz    = r_dz;

endmodule

// File: tb/tb_recip_prenorm.sv
// Directed checks of recip_prenorm at W=16: results, latency,
// backpressure and reset behaviour.
module tb_recip_prenorm;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_valid;
  logic        o_ready;
  logic [15:0] i_divisor;
  logic        o_valid;
  logic        i_ready;
  logic [15:0] o_x;
  logic [15:0] o_x0;
  logic [3:0]  o_shift;
  logic        o_dz;

  int n_cmp = 0;
  int n_bad = 0;

  recip_prenorm #(.W(16)) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_valid   (i_valid),
    .o_ready   (o_ready),
    .i_divisor (i_divisor),
    .o_valid   (o_valid),
    .i_ready   (i_ready),
    .o_x       (o_x),
    .o_x0      (o_x0),
    .o_shift   (o_shift),
    .o_dz      (o_dz)
  );

  always #5 clk = ~clk;

  // lat = edges after the accepting edge until o_valid is seen;
  // 0 means o_valid was already high after the accepting edge.
  task automatic send(input logic [15:0] d, output int lat);
    @(negedge clk);
    i_valid   = 1'b1;
    i_divisor = d;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    lat = -1;
    if (o_valid) begin
      lat = 0;
      return;
    end
    for (int n = 1; n <= 64; n++) begin
      @(posedge clk);
      #1;
      if (o_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    i_valid   = 1'b1;
    i_divisor = 16'h1234;
    i_ready   = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_hs got rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
    n_cmp++;
    if ({o_x, o_x0, o_shift, o_dz} !== 37'd0) begin
      n_bad++;
      $display("FAIL reset_out got x=%h x0=%h sh=%0d dz=%b want 0",
               o_x, o_x0, o_shift, o_dz);
    end
    @(negedge clk);
    rst     = 1'b0;
    i_valid = 1'b0;
  endtask

  task automatic test_c000();
    int lat;
    send(16'hC000, lat);
    n_cmp++;
    if (lat !== 17) begin
      n_bad++;
      $display("FAIL c000_lat got %0d want 17", lat);
    end
    n_cmp++;
    if (o_x !== 16'hC000 || o_shift !== 4'd0) begin
      n_bad++;
      $display("FAIL c000_x got x=%h sh=%0d want c000 0", o_x, o_shift);
    end
    n_cmp++;
    if (o_x0 !== 16'h5A5B || o_dz !== 1'b0) begin
      n_bad++;
      $display("FAIL c000_x0 got x0=%h dz=%b want 5a5b 0", o_x0, o_dz);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL c000_idle got rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
  endtask

  task automatic test_0003();
    int lat;
    send(16'h0003, lat);
    n_cmp++;
    if (lat !== 31) begin
      n_bad++;
      $display("FAIL d3_lat got %0d want 31", lat);
    end
    n_cmp++;
    if (o_x !== 16'hC000 || o_shift !== 4'd14 || o_x0 !== 16'h5A5B) begin
      n_bad++;
      $display("FAIL d3_res got x=%h sh=%0d x0=%h want c000 14 5a5b",
               o_x, o_shift, o_x0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_0001();
    int lat;
    send(16'h0001, lat);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++;
      $display("FAIL d1_lat got %0d want 32", lat);
    end
    n_cmp++;
    if (o_x !== 16'h8000 || o_shift !== 4'd15 || o_x0 !== 16'h7879) begin
      n_bad++;
      $display("FAIL d1_res got x=%h sh=%0d x0=%h want 8000 15 7879",
               o_x, o_shift, o_x0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_zero();
    int lat;
    send(16'h0000, lat);
    n_cmp++;
    if (lat !== 0) begin
      n_bad++;
      $display("FAIL zero_valid_next_cycle got lat=%0d want 0", lat);
    end
    n_cmp++;
    if (o_dz !== 1'b1 || o_x !== 16'h0 || o_x0 !== 16'h0 || o_shift !== 4'd0) begin
      n_bad++;
      $display("FAIL zero_res got dz=%b x=%h x0=%h sh=%0d want 1 0 0 0",
               o_dz, o_x, o_x0, o_shift);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL zero_idle got rdy=%b want 1", o_ready);
    end
  endtask

  task automatic test_backpressure();
    int lat;
    @(negedge clk);
    i_ready = 1'b0;
    send(16'h0001, lat);
    n_cmp++;
    if (lat !== 32) begin
      n_bad++;
      $display("FAIL bp_lat got %0d want 32", lat);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      i_valid   = ~i_valid;
      i_divisor = 16'hC000;
      @(posedge clk);
      #1;
      n_cmp++;
      if (o_valid !== 1'b1 || o_ready !== 1'b0 || o_x !== 16'h8000 ||
          o_x0 !== 16'h7879 || o_shift !== 4'd15 || o_dz !== 1'b0) begin
        n_bad++;
        $display("FAIL bp_hold%0d got vld=%b rdy=%b x=%h x0=%h sh=%0d",
                 i, o_valid, o_ready, o_x, o_x0, o_shift);
      end
    end
    @(negedge clk);
    i_valid = 1'b0;
    i_ready = 1'b1;
    @(posedge clk);
    #1;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_release got rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
    send(16'hC000, lat);
    n_cmp++;
    if (lat !== 17 || o_x !== 16'hC000 || o_x0 !== 16'h5A5B) begin
      n_bad++;
      $display("FAIL bp_next got lat=%0d x=%h x0=%h want 17 c000 5a5b",
               lat, o_x, o_x0);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_mid_reset();
    int lat;
    @(negedge clk);
    i_valid   = 1'b1;
    i_divisor = 16'h0003;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    n_cmp++;
    if (o_ready !== 1'b1 || o_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_hs got rdy=%b vld=%b want 1 0", o_ready, o_valid);
    end
    n_cmp++;
    if ({o_x, o_x0, o_shift, o_dz} !== 37'd0) begin
      n_bad++;
      $display("FAIL mrst_out got x=%h x0=%h sh=%0d dz=%b want 0",
               o_x, o_x0, o_shift, o_dz);
    end
    send(16'hC000, lat);
    n_cmp++;
    if (lat !== 17 || o_x !== 16'hC000 || o_x0 !== 16'h5A5B ||
        o_shift !== 4'd0 || o_dz !== 1'b0) begin
      n_bad++;
      $display("FAIL mrst_next got lat=%0d x=%h x0=%h sh=%0d dz=%b",
               lat, o_x, o_x0, o_shift, o_dz);
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    i_valid   = 1'b0;
    i_divisor = '0;
    i_ready   = 1'b1;
    test_reset();
    test_c000();
    test_0003();
    test_0001();
    test_zero();
    test_backpressure();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
